// File: rtl/mem_data_skew_if.sv
// Bus bundle for mem_data_skew: stream-side controls and word in, staggered lanes out.
interface mem_data_skew_if #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ARRAY          = 16,
  parameter int unsigned MEM_DATA_WIDTH = DATA_WIDTH * ARRAY
);
  logic                      en;
  logic                      flush;
  logic                      in_valid;
  logic [MEM_DATA_WIDTH-1:0] data_in;
  logic [MEM_DATA_WIDTH-1:0] data_out;
  logic [ARRAY-1:0]          out_valid;
  logic                      busy;

  modport master (
    output en, flush, in_valid, data_in,
    input  data_out, out_valid, busy
  );

  modport slave (
    input  en, flush, in_valid, data_in,
    output data_out, out_valid, busy
  );
endinterface

// File: rtl/mem_data_skew.sv
// Lane-staggering pipeline: lane n of each word is delayed by D(n) enabled cycles,
// growing with n (skew) or shrinking with n (deskew), with per-lane valid bits.
module mem_data_skew #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ARRAY          = 16,
  parameter int unsigned BASE_DELAY     = 1,
  parameter int unsigned DIRECTION      = 0,
  parameter int unsigned ZERO_FILL      = 1,
  parameter int unsigned MEM_DATA_WIDTH = DATA_WIDTH * ARRAY
) (
  input  logic           clk,
  input  logic           reset,
  mem_data_skew_if.slave bus
);

  logic [MEM_DATA_WIDTH-1:0] data_out_w;
  logic [ARRAY-1:0]          valid_out_w;
  logic [ARRAY-1:0]          lane_busy;

  for (genvar n = 0; n < ARRAY; n++) begin : g_lane
    localparam int unsigned DEPTH =
      BASE_DELAY + ((DIRECTION == 0) ? n : (ARRAY - 1 - n));

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] entry_data;

    // Bubbles optionally enter as zero so idle lanes present clean data to the array.
    assign entry_data = ((ZERO_FILL != 0) && !bus.in_valid)
                        ? '0 : bus.data_in[n*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
      end else if (bus.en) begin
        valid_q[0] <= bus.in_valid;
        data_q[0]  <= entry_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign data_out_w[n*DATA_WIDTH +: DATA_WIDTH] = data_q[DEPTH-1];
    assign valid_out_w[n]                         = valid_q[DEPTH-1];
    assign lane_busy[n]                           = |valid_q;
  end

  assign bus.data_out  = data_out_w;
  assign bus.out_valid = valid_out_w;
  assign bus.busy      = |lane_busy;

endmodule

// File: tb/tb_mem_data_skew.sv
// Scoreboard bench for mem_data_skew: four configurations share one stimulus stream,
// plus a skew->deskew chain whose realignment is measured directly.
module tb_mem_data_skew;

  localparam int NL   = 4;
  localparam int NDUT = 4;

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    int unsigned due;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset, en, flush, in_valid;
  logic [31:0] data_in;

  int unsigned total  = 0;
  int unsigned bad    = 0;
  int unsigned ecount = 0;

  slot_t      sbq   [NDUT][NL][$];
  logic [7:0] exp_d [NDUT][NL];
  logic       exp_v [NDUT][NL];

  always #5 clk = ~clk;

  mem_data_skew_if #(.DATA_WIDTH(8), .ARRAY(4)) sk_if ();
  mem_data_skew_if #(.DATA_WIDTH(8), .ARRAY(4)) ds_if ();
  mem_data_skew_if #(.DATA_WIDTH(8), .ARRAY(4)) nz_if ();
  mem_data_skew_if #(.DATA_WIDTH(8), .ARRAY(4)) b3_if ();
  mem_data_skew_if #(.DATA_WIDTH(8), .ARRAY(4)) rt_if ();

  assign sk_if.en = en;  assign sk_if.flush = flush;  assign sk_if.in_valid = in_valid;  assign sk_if.data_in = data_in;
  assign ds_if.en = en;  assign ds_if.flush = flush;  assign ds_if.in_valid = in_valid;  assign ds_if.data_in = data_in;
  assign nz_if.en = en;  assign nz_if.flush = flush;  assign nz_if.in_valid = in_valid;  assign nz_if.data_in = data_in;
  assign b3_if.en = en;  assign b3_if.flush = flush;  assign b3_if.in_valid = in_valid;  assign b3_if.data_in = data_in;
  assign rt_if.en = en;  assign rt_if.flush = flush;
  assign rt_if.in_valid = |sk_if.out_valid;
  assign rt_if.data_in  = sk_if.data_out;

  mem_data_skew #(.DATA_WIDTH(8), .ARRAY(4), .BASE_DELAY(1), .DIRECTION(0), .ZERO_FILL(1))
    u_skew (.clk(clk), .reset(reset), .bus(sk_if));
  mem_data_skew #(.DATA_WIDTH(8), .ARRAY(4), .BASE_DELAY(1), .DIRECTION(1), .ZERO_FILL(1))
    u_deskew (.clk(clk), .reset(reset), .bus(ds_if));
  mem_data_skew #(.DATA_WIDTH(8), .ARRAY(4), .BASE_DELAY(1), .DIRECTION(0), .ZERO_FILL(0))
    u_nofill (.clk(clk), .reset(reset), .bus(nz_if));
  mem_data_skew #(.DATA_WIDTH(8), .ARRAY(4), .BASE_DELAY(3), .DIRECTION(0), .ZERO_FILL(1))
    u_base3 (.clk(clk), .reset(reset), .bus(b3_if));
  mem_data_skew #(.DATA_WIDTH(8), .ARRAY(4), .BASE_DELAY(1), .DIRECTION(1), .ZERO_FILL(1))
    u_round (.clk(clk), .reset(reset), .bus(rt_if));

  logic [31:0] obs_d [NDUT];
  logic [3:0]  obs_v [NDUT];
  logic        obs_b [NDUT];
  assign obs_d[0] = sk_if.data_out;  assign obs_v[0] = sk_if.out_valid;  assign obs_b[0] = sk_if.busy;
  assign obs_d[1] = ds_if.data_out;  assign obs_v[1] = ds_if.out_valid;  assign obs_b[1] = ds_if.busy;
  assign obs_d[2] = nz_if.data_out;  assign obs_v[2] = nz_if.out_valid;  assign obs_b[2] = nz_if.busy;
  assign obs_d[3] = b3_if.data_out;  assign obs_v[3] = b3_if.out_valid;  assign obs_b[3] = b3_if.busy;

  function automatic int unsigned dly(input int k, input int n);
    case (k)
      0:       return 1 + n;
      1:       return 1 + (NL - 1 - n);
      2:       return 1 + n;
      default: return 3 + n;
    endcase
  endfunction

  function automatic logic zf(input int k);
    return (k != 2);
  endfunction

  function automatic string dname(input int k);
    case (k)
      0:       return "skew";
      1:       return "deskew";
      2:       return "nofill";
      default: return "base3";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] want_d;
    logic [3:0]  want_v;
    logic        want_b;
    for (int k = 0; k < NDUT; k++) begin
      want_d = '0;
      want_v = '0;
      want_b = 1'b0;
      for (int n = 0; n < NL; n++) begin
        want_d[n*8 +: 8] = exp_d[k][n];
        want_v[n]        = exp_v[k][n];
        want_b           = want_b | exp_v[k][n];
        for (int i = 0; i < sbq[k][n].size(); i++) begin
          want_b = want_b | sbq[k][n][i].v;
        end
      end
      check({dname(k), "_data"},  obs_d[k], want_d);
      check({dname(k), "_valid"}, {28'd0, obs_v[k]}, {28'd0, want_v});
      check({dname(k), "_busy"},  {31'd0, obs_b[k]}, {31'd0, want_b});
    end
  endtask

  // Advance one clock; the model pushes entry slots and pops those now due at the outputs.
  task automatic tick();
    logic        clr, adv, iv;
    logic [31:0] din;
    slot_t       s;
    clr = reset || flush;
    adv = en;
    iv  = in_valid;
    din = data_in;
    @(posedge clk);
    #1;
    if (clr) begin
      for (int k = 0; k < NDUT; k++) begin
        for (int n = 0; n < NL; n++) begin
          sbq[k][n].delete();
          exp_d[k][n] = '0;
          exp_v[k][n] = 1'b0;
        end
      end
    end else if (adv) begin
      ecount++;
      for (int k = 0; k < NDUT; k++) begin
        for (int n = 0; n < NL; n++) begin
          s.v   = iv;
          s.d   = (!iv && zf(k)) ? 8'h00 : din[n*8 +: 8];
          s.due = ecount + dly(k, n) - 1;
          sbq[k][n].push_back(s);
          if (sbq[k][n].size() > 0 && sbq[k][n][0].due == ecount) begin
            s = sbq[k][n].pop_front();
            exp_v[k][n] = s.v;
            exp_d[k][n] = s.d;
          end else begin
            exp_v[k][n] = 1'b0;
            exp_d[k][n] = '0;
          end
        end
      end
    end
    compare_all();
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    data_in  = '0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic issue(input logic [31:0] w);
    in_valid = 1'b1;
    data_in  = w;
    tick();
  endtask

  initial begin
    int edges;
    reset = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; data_in = '0;
    tick();
    tick();
    reset = 1'b0;
    en    = 1'b1;
    idle(1);

    // single skewed word, and the skew->deskew chain realigning it
    issue(32'h44332211);
    in_valid = 1'b0;
    data_in  = '0;
    edges    = 1;
    while (rt_if.out_valid != 4'hF && edges < 20) begin
      tick();
      edges++;
    end
    check("roundtrip_edges", edges, 5);
    check("roundtrip_data", rt_if.data_out, 32'h44332211);
    idle(8);

    issue(32'hDDCCBBAA);
    idle(8);

    // stream with a 3-cycle stall in the middle
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        en       = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        en = 1'b1;
      end
      issue(32'h04030201 + 32'h04040404 * i);
    end
    idle(8);

    // flush two cycles after a word, coinciding with a new valid word
    issue(32'h0F0E0D0C);
    idle(1);
    flush = 1'b1;
    issue(32'h13121110);
    flush = 1'b0;
    idle(8);

    // alternating bubbles with all-ones data
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      data_in  = 32'hFFFFFFFF;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    idle(8);

    // reset together with flush and enable during traffic
    issue(32'h21222324);
    issue(32'h31323334);
    issue(32'h41424344);
    reset = 1'b1;
    flush = 1'b1;
    issue(32'h51525354);
    reset = 1'b0;
    flush = 1'b0;
    issue(32'hA1B2C3D4);
    idle(10);

    // flush and reset still clear while stalled
    issue(32'h66778899);
    en    = 1'b0;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    en    = 1'b1;
    issue(32'h5A6B7C8D);
    en    = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    en    = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
